issue_scheduler: RTL and testbench
==================================

ISSUE_SCHEDULER -- requirements
Module: issue_scheduler

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, number of instruction queue slots.
REQ-002 SHALL have parameter ADDR_WIDTH, default $clog2(ENTRIES), slot index width.
REQ-003 SHALL have parameter PHYS_ADDR_WIDTH, default 7, physical register tag width (128 registers).
REQ-004 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-005 SHALL have port async_rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port clk_en, input, 1, global state-update enable.
REQ-007 SHALL have port flush, input, 1, discard all queued entries.
REQ-008 SHALL have port disp_valid, input, 1, dispatch request.
REQ-009 SHALL have port disp_ready, output, 1, slot available.
REQ-010 SHALL have ports disp_src0_tag and disp_src1_tag, input, PHYS_ADDR_WIDTH each, source tags.
REQ-011 SHALL have ports disp_src0_valid and disp_src1_valid, input, 1 each, source used.
REQ-012 SHALL have ports disp_src0_rdy and disp_src1_rdy, input, 1 each, source already available at dispatch.
REQ-013 SHALL have ports wb_valid, input, 1 and wb_tag, input, PHYS_ADDR_WIDTH, writeback wakeup broadcast.
REQ-014 SHALL have ports iq_wr_en, output, 1 and iq_wr_addr, output, ADDR_WIDTH, queue write control.
REQ-015 SHALL have ports iq_rd_en, output, 1 and iq_rd_addr, output, ADDR_WIDTH, queue read control.
REQ-016 SHALL have port issue_ready, input, 1, functional unit accepts an instruction.
REQ-017 SHALL have ports issue_valid, output, 1 and issue_addr, output, ADDR_WIDTH, registered issue strobe aligned to queue read data.
REQ-018 SHALL have port occupancy, output, ADDR_WIDTH+1, count of valid entries.
REQ-019 SHALL have port stall_cnt, output, 32, no-ready-entry cycle counter.

Function
REQ-020 SHALL hold per slot: valid, src0/src1 tag, src0/src1 ready, and an ENTRIES x ENTRIES age matrix.
REQ-021 SHALL drive disp_ready = (occupancy < ENTRIES), from registered state only.
REQ-022 SHALL accept dispatch when disp_valid & disp_ready & clk_en & ~flush, asserting iq_wr_en with iq_wr_addr = lowest-index free slot, same cycle.
REQ-023 SHALL write a slot's source ready as (~srcN_valid | srcN_rdy | (wb_valid & wb_tag == srcN_tag)), so same-cycle wakeup is never lost.
REQ-024 SHALL set srcN ready on every valid slot whose tag matches wb_tag when wb_valid & clk_en.
REQ-025 SHALL treat a slot as eligible when valid and both source ready bits set, from registered state; a slot is eligible no earlier than the cycle after dispatch or wakeup.
REQ-026 SHALL select the oldest eligible slot by age matrix; dispatched slot is younger than all valid slots.
REQ-027 SHALL assert iq_rd_en with iq_rd_addr = selected slot when any eligible & issue_ready & clk_en & ~flush; the slot is freed at that edge.
REQ-028 SHALL register issue_valid = iq_rd_en and issue_addr = iq_rd_addr (1-cycle latency).
REQ-029 SHALL keep occupancy unchanged on simultaneous accept and issue; +1 on accept only; -1 on issue only.
REQ-030 SHALL allow the slot freed by issue to be reused only from the next cycle.
REQ-031 SHALL on flush (with clk_en) clear all valids, occupancy to 0, suppress iq_wr_en and iq_rd_en; issue_valid 0 next cycle.
REQ-032 SHALL with clk_en low hold all state and drive iq_wr_en, iq_rd_en low.

Reset
REQ-033 SHALL on async_rst, immediately and mid-operation, clear all valids and age matrix, occupancy 0, issue_valid 0, issue_addr 0, stall_cnt 0.
REQ-034 SHALL after reset release present disp_ready 1, iq_wr_en 0, iq_rd_en 0, iq_wr_addr 0, iq_rd_addr 0.

Configuration
REQ-035 SHALL with ISSUE_STALL_CNT_EN defined increment stall_cnt (saturating at 2^32-1) each clk_en cycle with occupancy > 0 and no eligible slot.
REQ-036 SHALL without ISSUE_STALL_CNT_EN tie stall_cnt to 0 and contain no counter logic.

Verification
REQ-037 Dispatch tags 5,6 both rdy at cycle 0, issue_ready=1 -> iq_wr_addr=0 cycle 0, iq_rd_en with addr 0 cycle 1, issue_valid cycle 2.
REQ-038 Fill 16 slots -> occupancy=16, disp_ready=0; issue one -> disp_ready=1 next cycle, refill uses freed slot.
REQ-039 Slots 0,1 wait on tag 9, slot 1 older by reinsertion; wb_tag=9 -> slot 1 issues first, slot 0 next cycle.
REQ-040 Dispatch src0 tag 12 not rdy with wb_valid, wb_tag=12 same cycle -> slot eligible next cycle.
REQ-041 Flush with 8 valid entries -> occupancy 0, no iq_rd_en, issue_valid 0 next cycle; async_rst mid-stream -> all outputs reset values.
REQ-042 ISSUE_STALL_CNT_EN: 3 entries blocked 10 cycles -> stall_cnt=10; without macro -> 0.

Source files
------------

// File: rtl/issue_scheduler.sv
// issue_scheduler: out-of-order issue scheduler with an age matrix.
// Dispatch goes to the lowest free slot. A writeback broadcast wakes up
// matching sources. The oldest slot with both sources ready is issued.
// Optional build macro: ISSUE_STALL_CNT_EN enables the stall cycle counter.
`timescale 1ns/1ps
module issue_scheduler #(
    parameter int ENTRIES         = 16,
    parameter int ADDR_WIDTH      = $clog2(ENTRIES),
    parameter int PHYS_ADDR_WIDTH = 7
) (
    input  logic                       clk,
    input  logic                       async_rst,
    input  logic                       clk_en,
    input  logic                       flush,
    input  logic                       disp_valid,
    output logic                       disp_ready,
    input  logic [PHYS_ADDR_WIDTH-1:0] disp_src0_tag,
    input  logic [PHYS_ADDR_WIDTH-1:0] disp_src1_tag,
    input  logic                       disp_src0_valid,
    input  logic                       disp_src1_valid,
    input  logic                       disp_src0_rdy,
    input  logic                       disp_src1_rdy,
    input  logic                       wb_valid,
    input  logic [PHYS_ADDR_WIDTH-1:0] wb_tag,
    output logic                       iq_wr_en,
    output logic [ADDR_WIDTH-1:0]      iq_wr_addr,
    output logic                       iq_rd_en,
    output logic [ADDR_WIDTH-1:0]      iq_rd_addr,
    input  logic                       issue_ready,
    output logic                       issue_valid,
    output logic [ADDR_WIDTH-1:0]      issue_addr,
    output logic [ADDR_WIDTH:0]        occupancy,
    output logic [31:0]                stall_cnt
);

    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(ENTRIES);

    // Per-slot state. age_reg[i][j] set means slot i is older than slot j.
    logic [ENTRIES-1:0]         valid_reg;
    logic [ENTRIES-1:0]         src0_rdy_reg;
    logic [ENTRIES-1:0]         src1_rdy_reg;
    logic [PHYS_ADDR_WIDTH-1:0] src0_tag_reg [ENTRIES];
    logic [PHYS_ADDR_WIDTH-1:0] src1_tag_reg [ENTRIES];
    logic [ENTRIES-1:0]         age_reg      [ENTRIES];
    logic [ADDR_WIDTH:0]        occupancy_reg;
    logic                       issue_valid_reg;
    logic [ADDR_WIDTH-1:0]      issue_addr_reg;

    logic [ENTRIES-1:0]    eligible;
    logic [ENTRIES-1:0]    select;
    logic [ENTRIES-1:0]    blocker [ENTRIES];
    logic                  any_eligible;
    logic                  accept;
    logic                  issue;
    logic [ADDR_WIDTH-1:0] free_idx;
    logic [ADDR_WIDTH-1:0] sel_idx;
    logic                  src0_rdy_in;
    logic                  src1_rdy_in;

    // A slot is selected when it is eligible and no other eligible slot is older.
    genvar gi, gj;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_slot
            assign eligible[gi] = valid_reg[gi] & src0_rdy_reg[gi] & src1_rdy_reg[gi];
            for (gj = 0; gj < ENTRIES; gj++) begin : g_blk
                assign blocker[gi][gj] = eligible[gj] & age_reg[gj][gi];
            end
            assign select[gi] = eligible[gi] & ~(|blocker[gi]);
        end
    endgenerate

    // Lowest-index free slot for dispatch.
    always_comb begin
        free_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid_reg[i]) free_idx = ADDR_WIDTH'(i);
        end
    end

    // Encode the selected (oldest eligible) slot.
    always_comb begin
        sel_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (select[i]) sel_idx = ADDR_WIDTH'(i);
        end
    end

    assign any_eligible = |eligible;
    assign disp_ready   = (occupancy_reg < FULL_COUNT);
    assign accept       = disp_valid & disp_ready & clk_en & ~flush;
    assign issue        = any_eligible & issue_ready & clk_en & ~flush;

    // Fold in a same-cycle writeback so that the wakeup is not lost.
    assign src0_rdy_in = ~disp_src0_valid | disp_src0_rdy | (wb_valid & (wb_tag == disp_src0_tag));
    assign src1_rdy_in = ~disp_src1_valid | disp_src1_rdy | (wb_valid & (wb_tag == disp_src1_tag));

    assign iq_wr_en    = accept;
    assign iq_wr_addr  = free_idx;
    assign iq_rd_en    = issue;
    assign iq_rd_addr  = sel_idx;
    assign issue_valid = issue_valid_reg;
    assign issue_addr  = issue_addr_reg;
    assign occupancy   = occupancy_reg;

    // Slot state: wakeup, issue free, dispatch allocate, age update, occupancy.
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            valid_reg       <= '0;
            src0_rdy_reg    <= '0;
            src1_rdy_reg    <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                src0_tag_reg[i] <= '0;
                src1_tag_reg[i] <= '0;
                age_reg[i]      <= '0;
            end
            occupancy_reg   <= '0;
            issue_valid_reg <= 1'b0;
            issue_addr_reg  <= '0;
        end else if (clk_en) begin
            issue_valid_reg <= issue;
            issue_addr_reg  <= sel_idx;
            if (flush) begin
                valid_reg     <= '0;
                occupancy_reg <= '0;
            end else begin
                for (int i = 0; i < ENTRIES; i++) begin
                    if (wb_valid && valid_reg[i]) begin
                        if (src0_tag_reg[i] == wb_tag) src0_rdy_reg[i] <= 1'b1;
                        if (src1_tag_reg[i] == wb_tag) src1_rdy_reg[i] <= 1'b1;
                    end
                end
                if (issue) valid_reg[sel_idx] <= 1'b0;
                if (accept) begin
                    valid_reg[free_idx]    <= 1'b1;
                    src0_tag_reg[free_idx] <= disp_src0_tag;
                    src1_tag_reg[free_idx] <= disp_src1_tag;
                    src0_rdy_reg[free_idx] <= src0_rdy_in;
                    src1_rdy_reg[free_idx] <= src1_rdy_in;
                    // New entry is younger than every currently valid slot.
                    age_reg[free_idx] <= '0;
                    for (int j = 0; j < ENTRIES; j++) begin
                        age_reg[j][free_idx] <= valid_reg[j];
                    end
                end
                case ({accept, issue})
                    2'b10:   occupancy_reg <= occupancy_reg + 1'b1;
                    2'b01:   occupancy_reg <= occupancy_reg - 1'b1;
                    default: occupancy_reg <= occupancy_reg;
                endcase
            end
        end
    end

`ifdef ISSUE_STALL_CNT_EN
    logic [31:0] stall_cnt_reg;

    // Count enabled cycles where entries are resident but none can issue.
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            stall_cnt_reg <= '0;
        end else if (clk_en && (occupancy_reg != '0) && !any_eligible
                     && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_issue_scheduler.sv
// Self-checking bench for issue_scheduler: expected issue slots are queued
// when the issue is requested and compared when issue_valid appears.
`timescale 1ns/1ps
module tb_issue_scheduler;

    localparam int AW = 4;
    localparam int TW = 7;

    logic          clk = 1'b0;
    logic          async_rst;
    logic          clk_en;
    logic          flush;
    logic          disp_valid;
    logic          disp_ready;
    logic [TW-1:0] disp_src0_tag;
    logic [TW-1:0] disp_src1_tag;
    logic          disp_src0_valid;
    logic          disp_src1_valid;
    logic          disp_src0_rdy;
    logic          disp_src1_rdy;
    logic          wb_valid;
    logic [TW-1:0] wb_tag;
    logic          iq_wr_en;
    logic [AW-1:0] iq_wr_addr;
    logic          iq_rd_en;
    logic [AW-1:0] iq_rd_addr;
    logic          issue_ready;
    logic          issue_valid;
    logic [AW-1:0] issue_addr;
    logic [AW:0]   occupancy;
    logic [31:0]   stall_cnt;

    int n_vec = 0;
    int n_err = 0;
    int exp_q[$];

    issue_scheduler #(.ENTRIES(16), .ADDR_WIDTH(AW), .PHYS_ADDR_WIDTH(TW)) dut (
        .clk             (clk),
        .async_rst       (async_rst),
        .clk_en          (clk_en),
        .flush           (flush),
        .disp_valid      (disp_valid),
        .disp_ready      (disp_ready),
        .disp_src0_tag   (disp_src0_tag),
        .disp_src1_tag   (disp_src1_tag),
        .disp_src0_valid (disp_src0_valid),
        .disp_src1_valid (disp_src1_valid),
        .disp_src0_rdy   (disp_src0_rdy),
        .disp_src1_rdy   (disp_src1_rdy),
        .wb_valid        (wb_valid),
        .wb_tag          (wb_tag),
        .iq_wr_en        (iq_wr_en),
        .iq_wr_addr      (iq_wr_addr),
        .iq_rd_en        (iq_rd_en),
        .iq_rd_addr      (iq_rd_addr),
        .issue_ready     (issue_ready),
        .issue_valid     (issue_valid),
        .issue_addr      (issue_addr),
        .occupancy       (occupancy),
        .stall_cnt       (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", tag, got, exp);
        end
    endtask

    // Expected stall count depends on whether the counter is built.
    function automatic logic [31:0] stall_exp(input int n);
`ifdef ISSUE_STALL_CNT_EN
        return 32'(n);
`else
        return 32'(n * 0);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        flush           = 1'b0;
        disp_valid      = 1'b0;
        disp_src0_tag   = '0;
        disp_src1_tag   = '0;
        disp_src0_valid = 1'b0;
        disp_src1_valid = 1'b0;
        disp_src0_rdy   = 1'b0;
        disp_src1_rdy   = 1'b0;
        wb_valid        = 1'b0;
        wb_tag          = '0;
        issue_ready     = 1'b0;
    endtask

    task automatic drive_disp(input int t0, input bit v0, input bit r0,
                              input int t1, input bit v1, input bit r1);
        disp_valid      = 1'b1;
        disp_src0_tag   = TW'(t0);
        disp_src0_valid = v0;
        disp_src0_rdy   = r0;
        disp_src1_tag   = TW'(t1);
        disp_src1_valid = v1;
        disp_src1_rdy   = r1;
    endtask

    // Issue monitor: one line per observed issue, compared against the queue.
    always @(negedge clk) begin
        if (!async_rst && issue_valid) begin
            $display("issue slot %0d", issue_addr);
            if (exp_q.size() == 0) begin
                check("issue_unexpected", 32'(issue_addr), 32'hFFFF_FFFF);
            end else begin
                check("issue_addr", 32'(issue_addr), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required $finish");
        $fatal(1);
    end

    initial begin
        async_rst = 1'b1;
        clk_en    = 1'b1;
        idle_inputs();

        // Reset state
        tick();
        check("rst_occ",     32'(occupancy), 32'd0);
        check("rst_iv",      32'(issue_valid), 32'd0);
        check("rst_stall",   32'(stall_cnt), 32'd0);
        async_rst = 1'b0;
        settle();
        check("rel_ready",   32'(disp_ready), 32'd1);
        check("rel_wr_en",   32'(iq_wr_en), 32'd0);
        check("rel_rd_en",   32'(iq_rd_en), 32'd0);
        check("rel_wr_addr", 32'(iq_wr_addr), 32'd0);
        check("rel_rd_addr", 32'(iq_rd_addr), 32'd0);
        tick();

        // Basic dispatch -> issue latency
        drive_disp(5, 1, 1, 6, 1, 1);
        issue_ready = 1'b1;
        settle();
        check("t1_wr_en",   32'(iq_wr_en), 32'd1);
        check("t1_wr_addr", 32'(iq_wr_addr), 32'd0);
        check("t1_rd_en0",  32'(iq_rd_en), 32'd0);
        tick();
        disp_valid = 1'b0;
        settle();
        check("t1_occ1",    32'(occupancy), 32'd1);
        check("t1_rd_en1",  32'(iq_rd_en), 32'd1);
        check("t1_rd_addr", 32'(iq_rd_addr), 32'd0);
        exp_q.push_back(0);
        tick();
        issue_ready = 1'b0;
        check("t1_occ0",    32'(occupancy), 32'd0);

        // Fill all slots, free one, refill it
        for (int i = 0; i < 16; i++) begin
            drive_disp(i + 40, 1, 1, 0, 0, 0);
            settle();
            check("fill_wr_addr", 32'(iq_wr_addr), 32'(i));
            tick();
        end
        check("full_occ",   32'(occupancy), 32'd16);
        check("full_ready", 32'(disp_ready), 32'd0);
        issue_ready = 1'b1;
        settle();
        check("full_wr_en", 32'(iq_wr_en), 32'd0);
        check("full_rd",    32'(iq_rd_addr), 32'd0);
        exp_q.push_back(0);
        tick();
        issue_ready = 1'b0;
        settle();
        check("refill_ready", 32'(disp_ready), 32'd1);
        check("refill_addr",  32'(iq_wr_addr), 32'd0);
        check("refill_wr_en", 32'(iq_wr_en), 32'd1);
        tick();
        disp_valid = 1'b0;
        check("refill_occ", 32'(occupancy), 32'd16);
        issue_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            settle();
            check("drain_rd", 32'(iq_rd_addr), 32'((k + 1) % 16));
            exp_q.push_back((k + 1) % 16);
            tick();
        end
        issue_ready = 1'b0;
        check("drain_occ", 32'(occupancy), 32'd0);

        // Age order after slot reuse
        drive_disp(1, 1, 1, 2, 1, 1);
        tick();
        drive_disp(9, 1, 0, 0, 0, 0);
        settle();
        check("age_y_addr", 32'(iq_wr_addr), 32'd1);
        tick();
        disp_valid  = 1'b0;
        issue_ready = 1'b1;
        settle();
        check("age_x_rd", 32'(iq_rd_addr), 32'd0);
        exp_q.push_back(0);
        tick();
        drive_disp(9, 1, 0, 0, 0, 0);
        settle();
        check("age_z_addr", 32'(iq_wr_addr), 32'd0);
        check("age_blk_rd", 32'(iq_rd_en), 32'd0);
        tick();
        disp_valid = 1'b0;
        wb_valid   = 1'b1;
        wb_tag     = TW'(9);
        settle();
        check("age_wb_rd_en", 32'(iq_rd_en), 32'd0);
        tick();
        wb_valid = 1'b0;
        settle();
        check("age_first", 32'(iq_rd_addr), 32'd1);
        exp_q.push_back(1);
        tick();
        check("age_second", 32'(iq_rd_addr), 32'd0);
        check("age_rd_en",  32'(iq_rd_en), 32'd1);
        exp_q.push_back(0);
        tick();
        issue_ready = 1'b0;

        // Same-cycle wakeup at dispatch
        drive_disp(12, 1, 0, 0, 0, 0);
        wb_valid    = 1'b1;
        wb_tag      = TW'(12);
        issue_ready = 1'b1;
        settle();
        check("bypass_wr_addr", 32'(iq_wr_addr), 32'd0);
        check("bypass_rd_en0",  32'(iq_rd_en), 32'd0);
        tick();
        disp_valid = 1'b0;
        wb_valid   = 1'b0;
        settle();
        check("bypass_rd_en1", 32'(iq_rd_en), 32'd1);
        check("bypass_rd",     32'(iq_rd_addr), 32'd0);
        exp_q.push_back(0);
        tick();
        issue_ready = 1'b0;

        // Flush with 8 entries
        for (int i = 0; i < 8; i++) begin
            drive_disp(i + 60, 1, 1, 0, 0, 0);
            settle();
            check("fl_wr_addr", 32'(iq_wr_addr), 32'(i));
            tick();
        end
        check("fl_occ8", 32'(occupancy), 32'd8);
        flush       = 1'b1;
        issue_ready = 1'b1;
        settle();
        check("fl_rd_en", 32'(iq_rd_en), 32'd0);
        check("fl_wr_en", 32'(iq_wr_en), 32'd0);
        tick();
        idle_inputs();
        settle();
        check("fl_occ0",  32'(occupancy), 32'd0);
        check("fl_iv",    32'(issue_valid), 32'd0);
        check("fl_ready", 32'(disp_ready), 32'd1);
        tick();

        // Asynchronous reset in the middle of an issue
        drive_disp(30, 1, 0, 0, 0, 0);
        tick();
        drive_disp(31, 1, 1, 0, 0, 0);
        tick();
        disp_valid  = 1'b0;
        issue_ready = 1'b1;
        settle();
        check("ar_rd", 32'(iq_rd_addr), 32'd1);
        tick();
        check("ar_pre_iv",   32'(issue_valid), 32'd1);
        check("ar_pre_addr", 32'(issue_addr), 32'd1);
        async_rst = 1'b1;
        settle();
        check("ar_occ",   32'(occupancy), 32'd0);
        check("ar_iv",    32'(issue_valid), 32'd0);
        check("ar_addr",  32'(issue_addr), 32'd0);
        check("ar_stall", 32'(stall_cnt), 32'd0);
        check("ar_ready", 32'(disp_ready), 32'd1);
        idle_inputs();
        tick();
        async_rst = 1'b0;
        settle();
        check("ar_rel_wr_en", 32'(iq_wr_en), 32'd0);
        check("ar_rel_rd_en", 32'(iq_rd_en), 32'd0);
        check("ar_rel_rd",    32'(iq_rd_addr), 32'd0);

        // Stall counting: three blocked entries resident for ten cycles
        for (int i = 0; i < 3; i++) begin
            drive_disp(20, 1, 0, 0, 0, 0);
            tick();
        end
        disp_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        issue_ready = 1'b1;
        settle();
        check("st_occ",   32'(occupancy), 32'd3);
        check("st_cnt10", stall_cnt, stall_exp(10));
        check("st_rd_en", 32'(iq_rd_en), 32'd0);
        clk_en = 1'b0;
        drive_disp(21, 1, 1, 0, 0, 0);
        wb_valid = 1'b1;
        wb_tag   = TW'(20);
        settle();
        check("ce_wr_en", 32'(iq_wr_en), 32'd0);
        check("ce_rd_en", 32'(iq_rd_en), 32'd0);
        tick();
        tick();
        check("ce_occ",   32'(occupancy), 32'd3);
        check("ce_stall", stall_cnt, stall_exp(10));
        clk_en     = 1'b1;
        disp_valid = 1'b0;
        settle();
        check("st_wb_rd_en", 32'(iq_rd_en), 32'd0);
        tick();
        wb_valid = 1'b0;
        settle();
        check("st_cnt11", stall_cnt, stall_exp(11));
        for (int i = 0; i < 3; i++) begin
            check("st_rd", 32'(iq_rd_addr), 32'(i));
            exp_q.push_back(i);
            tick();
        end
        issue_ready = 1'b0;
        check("st_occ0",   32'(occupancy), 32'd0);
        check("st_cnt_end", stall_cnt, stall_exp(11));
        tick();
        tick();

        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
